gauss_conv_engine: RTL and testbench

- Parametrised streaming 1-D convolution engine; successor to the fixed 5-tap Gaussian kernel constant.
- Takes unsigned samples over a valid/ready stream and keeps a TAPS-deep sample window.
- Computes one weighted sum per accepted sample on a single shared multiplier, then rounds, shifts and saturates the result.
- The kernel is run-time programmable through a coefficient write port. Sits beside the picoMIPS datapath as a filter coprocessor.

---
 rtl/gauss_conv_engine.sv | 156 +++++++++++++++
 tb/tb_gauss_conv_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gauss_conv_engine.sv
// Streaming 1-D convolution engine: TAPS-deep sample window, one shared multiplier,
// round/shift/saturate on the way out, run-time programmable kernel.
module gauss_conv_engine #(
    parameter int TAPS   = 5,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 7
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_sat,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    input  logic                     flush
);

    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW + 1;
    localparam logic [ACC_W:0] RND     = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [ACC_W:0] MAX_OUT = {{(ACC_W + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}};
    localparam logic [AW-1:0]  LAST_TAP = AW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Power-on kernel: the legacy 5-tap Gaussian, otherwise a unity centre tap.
    function automatic logic [COEF_W-1:0] coef_reset(input int idx);
        logic [COEF_W-1:0] c;
        c = '0;
        if (TAPS == 5) begin
            case (idx)
                0, 4:    c = COEF_W'(32'd17);
                1, 3:    c = COEF_W'(32'd29);
                2:       c = COEF_W'(32'd35);
                default: c = '0;
            endcase
        end else if (idx == TAPS / 2) begin
            c = COEF_W'(64'd1 << SHIFT);
        end else begin
            c = '0;
        end
        return c;
    endfunction

    state_t              state_r;
    logic [DATA_W-1:0]   win_r  [TAPS];
    logic [COEF_W-1:0]   coef_r [TAPS];
    logic [ACC_W-1:0]    acc_r;
    logic [AW-1:0]       tap_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_sat_r;

    logic                accept_s;
    logic [PROD_W-1:0]   prod_s;
    logic [ACC_W:0]      rounded_s;
    logic [ACC_W:0]      shifted_s;
    logic                sat_s;

    // flush steals the accept slot combinationally so no sample slips in alongside it
    assign in_ready  = in_ready_r & ~flush;
    assign accept_s  = in_valid & in_ready;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;

    // Shared multiplier, rounding and saturation detect
    always_comb begin
        prod_s    = PROD_W'(win_r[tap_r]) * PROD_W'(coef_r[tap_r]);
        rounded_s = {1'b0, acc_r} + RND;
        shifted_s = rounded_s >> SHIFT;
        sat_s     = (shifted_s > MAX_OUT);
    end

    // Coefficient bank: writable only while idle, reverts on reset
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < TAPS; i++) coef_r[i] <= coef_reset(i);
        end else if (coef_we && (state_r == IDLE) && (32'(coef_addr) < TAPS)) begin
            coef_r[coef_addr] <= coef_wdata;
        end else begin
            for (int i = 0; i < TAPS; i++) coef_r[i] <= coef_r[i];
        end
    end

    // Control FSM, sample window, accumulator and registered result
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_r     <= IDLE;
            for (int i = 0; i < TAPS; i++) win_r[i] <= '0;
            acc_r       <= '0;
            tap_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sat_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (flush) begin
                        for (int i = 0; i < TAPS; i++) win_r[i] <= '0;
                    end else if (accept_s) begin
                        for (int i = TAPS - 1; i > 0; i--) win_r[i] <= win_r[i-1];
                        win_r[0]   <= in_data;
                        acc_r      <= '0;
                        tap_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= MAC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MAC: begin
                    acc_r <= acc_r + ACC_W'(prod_s);
                    if (tap_r == LAST_TAP) begin
                        state_r <= OUT;
                    end else begin
                        tap_r <= tap_r + 1'b1;
                    end
                end
                OUT: begin
                    // First OUT cycle latches the result; it then holds until taken
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= sat_s ? {DATA_W{1'b1}} : shifted_s[DATA_W-1:0];
                        out_sat_r   <= sat_s;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= OUT;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gauss_conv_engine.sv
// Directed bench for gauss_conv_engine (default TAPS=5, 8-bit data/coefs, SHIFT=7)
// with hand-computed expected results.
module tb_gauss_conv_engine;

    logic       clk = 1'b0;
    logic       nReset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sat;
    logic       coef_we;
    logic [2:0] coef_addr;
    logic [7:0] coef_wdata;
    logic       flush;

    int vectors = 0;
    int miscompares = 0;

    gauss_conv_engine dut (
        .clk        (clk),
        .nReset     (nReset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Offer one sample at a negedge, wait for its result, check latency/data/sat.
    // With poke set, a coefficient write is pulsed during the MAC phase.
    task automatic send(input logic [7:0] d, input logic [7:0] exp_d, input logic exp_s,
                        input bit poke, input string tag);
        int k;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        if (poke) begin
            coef_we    = 1'b1;
            coef_addr  = 3'd2;
            coef_wdata = 8'd0;
            @(negedge clk);
            coef_we = 1'b0;
            k = 1;
        end
        while (out_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".latency"}, 32'(k), 32'd6);
        chk({tag, ".data"}, 32'(out_data), 32'(exp_d));
        chk({tag, ".sat"}, 32'(out_sat), 32'(exp_s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [7:0] held;
        nReset = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = 3'd0; coef_wdata = 8'd0; flush = 1'b0;

        // Reset state
        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.out_sat", 32'(out_sat), 32'd0);
        @(negedge clk);
        nReset = 1'b1;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Impulse through the default kernel
        send(8'd255, 8'd34, 1'b0, 1'b0, "imp0");
        send(8'd0,   8'd58, 1'b0, 1'b0, "imp1");
        send(8'd0,   8'd70, 1'b0, 1'b0, "imp2");
        send(8'd0,   8'd58, 1'b0, 1'b0, "imp3");
        send(8'd0,   8'd34, 1'b0, 1'b0, "imp4");

        // DC step of 200 (the impulse has just left tap 4 on the first sample)
        send(8'd200, 8'd27,  1'b0, 1'b0, "dc0");
        send(8'd200, 8'd72,  1'b0, 1'b0, "dc1");
        send(8'd200, 8'd127, 1'b0, 1'b0, "dc2");
        send(8'd200, 8'd172, 1'b0, 1'b0, "dc3");
        send(8'd200, 8'd198, 1'b0, 1'b0, "dc4");
        send(8'd200, 8'd198, 1'b0, 1'b0, "dc5");

        // Coefficient write during MAC must be dropped
        send(8'd200, 8'd198, 1'b0, 1'b1, "poke");
        send(8'd200, 8'd198, 1'b0, 1'b0, "after_poke");

        // Backpressure: result held, second sample waits for the handshake
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd200;
        @(negedge clk);
        in_data = 8'd100;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bp.latency", 32'(k), 32'd6);
        chk("bp.data", 32'(out_data), 32'd198);
        held = out_data;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.hold_data", 32'(out_data), 32'(held));
            chk("bp.hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.valid_drop", 32'(out_valid), 32'd0);
        chk("bp.idle_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.second_taken", 32'(in_ready), 32'd0);
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bp.second_latency", 32'(k), 32'd6);
        chk("bp.second_data", 32'(out_data), 32'd185);

        // Flush in IDLE blocks the offered sample and clears the window
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        #1;
        chk("flush.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        send(8'd100, 8'd13, 1'b0, 1'b0, "flush100");

        // Saturation with all coefficients at 64
        @(negedge clk);
        coef_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            coef_addr  = 3'(i);
            coef_wdata = 8'd64;
            @(negedge clk);
        end
        coef_we = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        send(8'd255, 8'd128, 1'b0, 1'b0, "sat1");
        send(8'd255, 8'd255, 1'b0, 1'b0, "sat2");
        send(8'd255, 8'd255, 1'b1, 1'b0, "sat3");
        send(8'd255, 8'd255, 1'b1, 1'b0, "sat4");
        send(8'd255, 8'd255, 1'b1, 1'b0, "sat5");

        // Async reset at tap 2, then the default kernel must be back
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd255;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nReset = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.out_data", 32'(out_data), 32'd0);
        chk("arst.out_sat", 32'(out_sat), 32'd0);
        @(negedge clk);
        nReset = 1'b1;
        #1;
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        send(8'd255, 8'd34, 1'b0, 1'b0, "arst_imp0");
        send(8'd0,   8'd58, 1'b0, 1'b0, "arst_imp1");

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
